// File: rtl/sync_upcount_ctl.sv
// sync_upcount_ctl
//   Programmable-limit up counter with a small run/stop FSM (IDLE, RUN, DONE).
//   Counts from 0 or a loaded value up to `limit`. At limit it either wraps
//   to 0 (free-run) or parks in DONE (one-shot). A registered one-cycle
//   terminal-count pulse follows every edge that counted at q == limit.
//
//   Optional feature macro: UPCOUNT_OVF_STICKY_EN
//     defined   : ovf is a sticky flag set with every tc and cleared only by
//                 clr or reset
//     undefined : ovf is tied low and no flop is built
//
// Ports
//   clk       in   1      clock, rising edge
//   reset     in   1      asynchronous reset, active low
//   en        in   1      count enable / start request
//   clr       in   1      synchronous clear (highest priority)
//   load      in   1      synchronous load of load_val
//   load_val  in   WIDTH  value loaded into q
//   limit     in   WIDTH  terminal value, sampled every cycle
//   oneshot   in   1      1 = stop at limit, 0 = wrap to 0
//   q         out  WIDTH  current count
//   tc        out  1      terminal-count pulse
//   busy      out  1      high while the FSM is in RUN
//   ovf       out  1      sticky terminal-count flag
module sync_upcount_ctl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            tc_q    <= tc_d;
        end
    end

    // Priority: clr > load > FSM-driven counting.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        tc_d    = 1'b0;
        if (clr) begin
            state_d = IDLE;
            q_d     = '0;
        end else if (load) begin
            q_d = load_val;
            if (state_q == DONE) begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // Entering RUN does not count; first increment is the next enabled edge.
                    if (en) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (q_q == limit) begin
                            tc_d = 1'b1;
                            if (oneshot) begin
                                state_d = DONE;
                            end else begin
                                q_d = '0;
                            end
                        end else begin
                            // Values above limit simply roll through 2^WIDTH-1 -> 0.
                            q_d = q_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign q    = q_q;
    assign tc   = tc_q;
    assign busy = (state_q == RUN);

`ifdef UPCOUNT_OVF_STICKY_EN
    logic ovf_q, ovf_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clr) begin
            ovf_d = 1'b0;
        end else if (tc_d) begin
            ovf_d = 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sync_upcount_ctl.sv
module tb_sync_upcount_ctl;

`ifdef UPCOUNT_OVF_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       en;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] limit;
    logic       oneshot;
    logic [3:0] q;
    logic       tc;
    logic       busy;
    logic       ovf;

    int total;
    int bad;

    sync_upcount_ctl #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .oneshot  (oneshot),
        .q        (q),
        .tc       (tc),
        .busy     (busy),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [3:0] eq, input logic etc,
                          input logic ebusy, input logic eovf);
        chk({tag, ".q"},    {28'd0, q}, {28'd0, eq});
        chk({tag, ".tc"},   {31'd0, tc}, {31'd0, etc});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, ebusy});
        chk({tag, ".ovf"},  {31'd0, ovf}, {31'd0, eovf});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = 4'h0;
        limit    = 4'h5;
        oneshot  = 1'b0;

        // reset state
        step();
        chk_st("rst", 4'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // free-run, limit 5
        en = 1'b1;
        step(); chk_st("fr_start", 4'h0, 1'b0, 1'b1, 1'b0);
        step(); chk_st("fr1", 4'h1, 1'b0, 1'b1, 1'b0);
        step(); chk_st("fr2", 4'h2, 1'b0, 1'b1, 1'b0);
        step(); chk_st("fr3", 4'h3, 1'b0, 1'b1, 1'b0);
        step(); chk_st("fr4", 4'h4, 1'b0, 1'b1, 1'b0);
        step(); chk_st("fr5", 4'h5, 1'b0, 1'b1, 1'b0);
        step(); chk_st("fr_wrap", 4'h0, 1'b1, 1'b1, STICKY);
        step(); chk_st("fr_after", 4'h1, 1'b0, 1'b1, STICKY);

        // pause in RUN
        en = 1'b0;
        step(); chk_st("pause", 4'h1, 1'b0, 1'b1, STICKY);
        en = 1'b1;

        // raise limit mid-run, count to 7 (passes 5 without tc)
        limit = 4'h9;
        step(); chk_st("lim9_2", 4'h2, 1'b0, 1'b1, STICKY);
        step(); step(); step();
        chk_st("lim9_5", 4'h5, 1'b0, 1'b1, STICKY);
        step(); step();
        chk_st("lim9_7", 4'h7, 1'b0, 1'b1, STICKY);

        // asynchronous reset away from the clock edge
        #2 reset = 1'b0;
        #1 chk_st("async_rst", 4'h0, 1'b0, 1'b0, 1'b0);
        step(); chk_st("rst_hold", 4'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // one-shot, limit 3
        limit   = 4'h3;
        oneshot = 1'b1;
        en      = 1'b1;
        step(); chk_st("os_start", 4'h0, 1'b0, 1'b1, 1'b0);
        step(); step(); step();
        chk_st("os3", 4'h3, 1'b0, 1'b1, 1'b0);
        step(); chk_st("os_done", 4'h3, 1'b1, 1'b0, STICKY);
        step(); chk_st("os_hold1", 4'h3, 1'b0, 1'b0, STICKY);
        step(); chk_st("os_hold2", 4'h3, 1'b0, 1'b0, STICKY);
        clr = 1'b1;
        step(); chk_st("os_clr", 4'h0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        en  = 1'b0;
        step(); chk_st("idle_hold", 4'h0, 1'b0, 1'b0, 1'b0);

        // limit 0, free-run: tc on every enabled edge
        oneshot = 1'b0;
        limit   = 4'h0;
        en      = 1'b1;
        step(); chk_st("l0_start", 4'h0, 1'b0, 1'b1, 1'b0);
        step(); chk_st("l0_tc1", 4'h0, 1'b1, 1'b1, STICKY);
        step(); chk_st("l0_tc2", 4'h0, 1'b1, 1'b1, STICKY);

        // load above limit, wrap through F -> 0 without tc; ovf holds across load
        en       = 1'b0;
        load     = 1'b1;
        load_val = 4'hE;
        limit    = 4'h2;
        step(); chk_st("ld_E", 4'hE, 1'b0, 1'b1, STICKY);
        load = 1'b0;
        en   = 1'b1;
        step(); chk_st("ld_F", 4'hF, 1'b0, 1'b1, STICKY);
        step(); chk_st("ld_0", 4'h0, 1'b0, 1'b1, STICKY);
        step(); chk_st("ld_1", 4'h1, 1'b0, 1'b1, STICKY);
        step(); chk_st("ld_2", 4'h2, 1'b0, 1'b1, STICKY);
        step(); chk_st("ld_wrap", 4'h0, 1'b1, 1'b1, STICKY);

        // priority: clr beats load beats en
        clr      = 1'b1;
        load     = 1'b1;
        load_val = 4'h9;
        step(); chk_st("p_clr", 4'h0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        step(); chk_st("p_ld_idle", 4'h9, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        step(); chk_st("p_run", 4'h9, 1'b0, 1'b1, 1'b0);
        load     = 1'b1;
        load_val = 4'h3;
        step(); chk_st("p_ld_run", 4'h3, 1'b0, 1'b1, 1'b0);
        load = 1'b0;
        en   = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
